// File: rtl/wave_scheduler_if.sv
// rtl/wave_scheduler_if.sv - wave scheduler control/status bundle
interface wave_scheduler_if #(
  parameter int NUM_SLOTS = 8
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic                 play;
  logic                 frame_tick;
  logic                 kill;
  logic [SLOT_W-1:0]    kill_slot;
  logic                 spawn;
  logic [SLOT_W-1:0]    spawn_slot;
  logic [NUM_SLOTS-1:0] alive_mask;
  logic [3:0]           wave;
  logic                 intermission;
  logic                 wave_active;
  logic                 wave_clear;

  modport master (
    output play, frame_tick, kill, kill_slot,
    input  spawn, spawn_slot, alive_mask, wave, intermission, wave_active, wave_clear
  );

  modport slave (
    input  play, frame_tick, kill, kill_slot,
    output spawn, spawn_slot, alive_mask, wave, intermission, wave_active, wave_clear
  );
endinterface

// File: rtl/wave_scheduler.sv
// rtl/wave_scheduler.sv - enemy wave sequencer: intermission, paced spawns, kill tracking
module wave_scheduler #(
  parameter int NUM_SLOTS  = 8,
  parameter int SPAWN_GAP  = 30,
  parameter int WAVE_DELAY = 120,
  parameter int MAX_WAVE   = 15
) (
  input  logic Clk,
  input  logic Reset_n,
  wave_scheduler_if.slave bus
);
  localparam int SLOT_W  = $clog2(NUM_SLOTS);
  localparam int CNT_MAX = (WAVE_DELAY > SPAWN_GAP) ? WAVE_DELAY : SPAWN_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, INTERMISSION, SPAWNING, FIGHT} state_t;

  state_t               state_q, state_d;
  logic [3:0]           wave_q, wave_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4:0]           spawn_idx_q, spawn_idx_d;
  logic [4:0]           target_q, target_d;
  logic [NUM_SLOTS-1:0] alive_q, alive_d;
  logic                 spawn_q, spawn_d;
  logic [SLOT_W-1:0]    spawn_slot_q, spawn_slot_d;
  logic                 wave_clear_q, wave_clear_d;
  logic                 intermission_q, intermission_d;
  logic                 wave_active_q, wave_active_d;
  logic [4:0]           target_raw;
  logic                 kill_ok;

  always_comb begin
    state_d      = state_q;
    wave_d       = wave_q;
    cnt_d        = cnt_q;
    spawn_idx_d  = spawn_idx_q;
    target_d     = target_q;
    alive_d      = alive_q;
    spawn_d      = 1'b0;
    spawn_slot_d = '0;
    wave_clear_d = 1'b0;
    target_raw   = {1'b0, wave_q} + 5'd3;
    kill_ok      = bus.kill && (32'(bus.kill_slot) < NUM_SLOTS);

    case (state_q)
      IDLE: begin
        alive_d = '0;
        wave_d  = '0;
        cnt_d   = '0;
        if (bus.play) begin
          state_d = INTERMISSION;
          wave_d  = 4'd1;
        end
      end
      INTERMISSION: begin
        if (bus.frame_tick) begin
          if (cnt_q == CNT_W'(WAVE_DELAY - 1)) begin
            state_d     = SPAWNING;
            spawn_idx_d = '0;
            // Preloading the gap counter makes the first tick after entry spawn.
            cnt_d       = CNT_W'(SPAWN_GAP - 1);
            target_d    = (target_raw > 5'(NUM_SLOTS)) ? 5'(NUM_SLOTS) : target_raw;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SPAWNING: begin
        if (kill_ok) alive_d[bus.kill_slot] = 1'b0;
        if (bus.frame_tick) begin
          if (cnt_q == CNT_W'(SPAWN_GAP - 1)) begin
            cnt_d        = '0;
            spawn_d      = 1'b1;
            spawn_slot_d = spawn_idx_q[SLOT_W-1:0];
            alive_d[spawn_idx_q[SLOT_W-1:0]] = 1'b1;
            spawn_idx_d  = spawn_idx_q + 5'd1;
            if (spawn_idx_d == target_q) state_d = FIGHT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FIGHT: begin
        if (kill_ok) alive_d[bus.kill_slot] = 1'b0;
        if (alive_q == '0) begin
          wave_clear_d = 1'b1;
          wave_d       = (wave_q >= 4'(MAX_WAVE)) ? 4'(MAX_WAVE) : wave_q + 4'd1;
          state_d      = INTERMISSION;
          cnt_d        = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Leaving play overrides everything, including a spawn due this cycle.
    if (!bus.play) begin
      state_d      = IDLE;
      alive_d      = '0;
      wave_d       = '0;
      cnt_d        = '0;
      spawn_idx_d  = '0;
      target_d     = '0;
      spawn_d      = 1'b0;
      spawn_slot_d = '0;
      wave_clear_d = 1'b0;
    end

    intermission_d = (state_d == INTERMISSION);
    wave_active_d  = (state_d == SPAWNING) || (state_d == FIGHT);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q        <= IDLE;
      wave_q         <= '0;
      cnt_q          <= '0;
      spawn_idx_q    <= '0;
      target_q       <= '0;
      alive_q        <= '0;
      spawn_q        <= 1'b0;
      spawn_slot_q   <= '0;
      wave_clear_q   <= 1'b0;
      intermission_q <= 1'b0;
      wave_active_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wave_q         <= wave_d;
      cnt_q          <= cnt_d;
      spawn_idx_q    <= spawn_idx_d;
      target_q       <= target_d;
      alive_q        <= alive_d;
      spawn_q        <= spawn_d;
      spawn_slot_q   <= spawn_slot_d;
      wave_clear_q   <= wave_clear_d;
      intermission_q <= intermission_d;
      wave_active_q  <= wave_active_d;
    end
  end

  assign bus.spawn        = spawn_q;
  assign bus.spawn_slot   = spawn_slot_q;
  assign bus.alive_mask   = alive_q;
  assign bus.wave         = wave_q;
  assign bus.intermission = intermission_q;
  assign bus.wave_active  = wave_active_q;
  assign bus.wave_clear   = wave_clear_q;
endmodule

// File: doc/wave_scheduler.md
# wave_scheduler

Sequences enemy waves while the game is in its play state. Runs intermission delays between waves and paces enemy spawns into a fixed pool of enemy slots. Tracks which slots are alive from kill reports, and advances the wave number when a wave is cleared. Sits between the game-state controller (`play`) and the enemy/collision logic (`spawn`, `kill`), timed by the per-frame tick from the VGA path.

## Interface
Parameters:
- NUM_SLOTS, 8, number of enemy slots (2..16); SLOT_W = $clog2(NUM_SLOTS)
- SPAWN_GAP, 30, frame ticks between consecutive spawns within a wave (≥1)
- WAVE_DELAY, 120, frame ticks of intermission before each wave (≥1)
- MAX_WAVE, 15, wave number saturation value (≤15)

Ports:
- Clk  in  1  system clock; single clock domain
- Reset_n  in  1  synchronous, active-low reset
- play  in  1  high while the game is in PLAY
- frame_tick  in  1  one-cycle pulse per video frame
- kill  in  1  one-cycle pulse: enemy in kill_slot destroyed
- kill_slot  in  SLOT_W  slot index qualified by kill
- spawn  out  1  one-cycle pulse: enemy spawned in spawn_slot
- spawn_slot  out  SLOT_W  slot index qualified by spawn
- alive_mask  out  NUM_SLOTS  bit i set = slot i holds a live enemy
- wave  out  4  current wave number (0 when idle, 1..MAX_WAVE)
- intermission  out  1  high in INTERMISSION
- wave_active  out  1  high in SPAWNING or FIGHT
- wave_clear  out  1  one-cycle pulse when a wave is cleared

## Operation
States: IDLE, INTERMISSION, SPAWNING, FIGHT.
- **IDLE:**
  - All outputs 0.
  - When `play`=1: go to INTERMISSION, wave←1, frame counter←0.
- **INTERMISSION:**
  - Counts frame_ticks.
  - On the WAVE_DELAY-th tick: go to SPAWNING, spawn_idx←0.
  - Set spawn target N = min(wave+3, NUM_SLOTS) (compute at 5 bits, then clamp).
- **SPAWNING:**
  - First spawn on the first frame_tick after entry.
  - Each later spawn comes SPAWN_GAP frame_ticks after the previous one.
  - Each spawn: spawn pulse, spawn_slot←spawn_idx, alive_mask[spawn_idx]←1, spawn_idx++.
  - After the N-th spawn: go to FIGHT.
- **FIGHT:**
  - When alive_mask==0: wave_clear pulse, wave←min(wave+1, MAX_WAVE), go to INTERMISSION, frame counter←0.
- **Kill handling (SPAWNING and FIGHT):**
  - `kill` clears alive_mask[kill_slot].
  - Kill of a non-alive slot is ignored.
  - Kill of out-of-range kill_slot (≥NUM_SLOTS) is ignored.
  - `kill` in IDLE or INTERMISSION is ignored.
- **Simultaneous kill and spawn on the same slot:** spawn wins; the bit ends set.
- **Simultaneous kill and spawn on different slots:** both take effect.
- **`play`=0 in any state:**
  - Next cycle: IDLE, alive_mask←0, wave←0, counters cleared.
  - No spawn, even if frame_tick is high in that cycle.
  - A later `play` rise restarts at wave 1.
- **Priority:** Reset_n low > play low > all else.

## Timing
- All outputs are registered.
- Reset value of every output is 0; state is IDLE.
- **State latency:**
  - State changes appear the cycle after the qualifying input.
  - `play` rise → intermission=1 and wave=1 in the next cycle.
- **spawn:**
  - Asserted in the cycle after the qualifying frame_tick, for exactly one cycle.
  - alive_mask bit updates in the same cycle as the pulse.
- **kill:** alive_mask bit clears in the cycle after the kill pulse.
- **wave_clear:**
  - Asserted in the cycle after alive_mask==0 is observed in FIGHT, for one cycle.
  - wave increments and intermission rises in that same cycle.
- **FIGHT with an empty mask:** a wave fully killed during SPAWNING only enters FIGHT after the N-th spawn, so the mask is non-empty on entry.
- **frame_tick during the state-entry cycle:** counts toward the new state's counter only from the cycle after entry.

## Test plan
Bench parameters: NUM_SLOTS=8, SPAWN_GAP=2, WAVE_DELAY=3.
- **Reset:** hold Reset_n=0 with play=1 and frame_ticks → all outputs 0, wave=0. Release → intermission=1, wave=1 the next cycle.
- **Wave 1 spawn:** play=1, 3 ticks → SPAWNING. Spawns of slots 0,1,2,3 follow ticks 1,3,5,7. Final alive_mask=8'h0F, wave_active=1, no further spawn.
- **Wave 1 clear:** kill slots 3,0,2,1 → mask 0x07, 0x06, 0x02, 0x00. Then one-cycle wave_clear, wave=2, intermission=1. Wave 2 ends with alive_mask=8'h1F.
- **Kill filtering:**
  - Kill slot 6 during wave 1 → mask unchanged.
  - Kill slot 0 during SPAWNING → bit 0 cleared while spawns continue.
  - Kill on the slot being spawned in the same cycle → bit set.
- **Saturation:**
  - Waves 5 and 6 each spawn 8 enemies (mask 8'hFF).
  - Clearing wave 15 leaves wave=15 and intermission=1.
- **Abort:**
  - Drop play mid-SPAWNING, coincident with a frame_tick → no spawn, next cycle all outputs 0.
  - Raise play → wave=1, intermission=1.
